// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the write-side FIFO serializer.
package fifo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } wser_state_t;

    // Beat counter width; RATIO is at least 2 so this is always >= 1.
    function automatic int beat_width(input int ratio);
        return (ratio > 2) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_serializer_sat_counter.sv
// Free-running event counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    output logic [CW-1:0] q
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/fifo_wr_serializer.sv
// Splits wide upstream words into RATIO FIFO beats (LSB beat first) and keeps
// saturating statistics on pushes, full-stalls and completed frames.
module fifo_wr_serializer
    import fifo_pkg::*;
#(
    parameter int DW    = 2,
    parameter int RATIO = 4,
    parameter int CW    = 16
) (
    input  logic               wclk,
    input  logic               wrst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [DW*RATIO-1:0] s_data,
    input  logic               s_last,
    input  logic               flush,
    output logic               fifo_wr,
    output logic [DW-1:0]      fifo_wdata,
    input  logic               fifo_wfull,
    output logic               busy,
    output logic [CW-1:0]      beats_pushed,
    output logic [CW-1:0]      stall_cycles,
    output logic [CW-1:0]      frames_sent
);

    localparam int BEAT_W = beat_width(RATIO);
    localparam int WW     = DW * RATIO;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

    wser_state_t       state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [WW-1:0]     shreg_q, shreg_d;
    logic              last_q, last_d;

    logic push, accept, at_last;

    // Handshakes: a word transfers when s_valid && s_ready in the same cycle;
    // a beat transfers when fifo_wr && !fifo_wfull. Neither side waits on the other's valid.
    assign fifo_wr    = (state_q == SEND);
    assign busy       = (state_q == SEND);
    assign fifo_wdata = shreg_q[DW-1:0];
    assign push       = fifo_wr && !fifo_wfull;
    assign at_last    = (beat_q == LAST_BEAT);
    // Ready on the last pushed beat lets the next word follow without a bubble.
    assign s_ready    = !flush && ((state_q == IDLE) || (push && at_last));
    assign accept     = s_valid && s_ready;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        shreg_d = shreg_q;
        last_d  = last_q;
        if (flush) begin
            state_d = IDLE;
            beat_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = SEND;
                        beat_d  = '0;
                        shreg_d = s_data;
                        last_d  = s_last;
                    end
                end
                SEND: begin
                    if (push) begin
                        if (!at_last) begin
                            shreg_d = shreg_q >> DW;
                            beat_d  = beat_q + BEAT_W'(1);
                        end else if (accept) begin
                            beat_d  = '0;
                            shreg_d = s_data;
                            last_d  = s_last;
                        end else begin
                            state_d = IDLE;
                            beat_d  = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            shreg_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            shreg_q <= shreg_d;
            last_q  <= last_d;
        end
    end

    sat_counter #(.CW(CW)) u_beats (
        .clk   (wclk),
        .rst_n (wrst),
        .inc   (push),
        .q     (beats_pushed)
    );

    sat_counter #(.CW(CW)) u_stalls (
        .clk   (wclk),
        .rst_n (wrst),
        .inc   (fifo_wr && fifo_wfull),
        .q     (stall_cycles)
    );

    // A flushed cycle may still push its beat, but it never completes a frame.
    sat_counter #(.CW(CW)) u_frames (
        .clk   (wclk),
        .rst_n (wrst),
        .inc   (push && at_last && last_q && !flush),
        .q     (frames_sent)
    );

endmodule

// File: tb/tb_fifo_wr_serializer.sv
// Directed bench for fifo_wr_serializer (DW=2, RATIO=4): a vector table for the
// streaming cases plus hand-written sequences for stall, flush, reset and saturation.
module tb_fifo_wr_serializer;

  localparam int DW    = 2;
  localparam int RATIO = 4;
  localparam int WW    = DW * RATIO;

  logic          wclk;
  logic          wrst;
  logic          s_valid;
  logic [WW-1:0] s_data;
  logic          s_last;
  logic          flush;
  logic          fifo_wfull;

  logic          s_ready, fifo_wr, busy;
  logic [DW-1:0] fifo_wdata;
  logic [15:0]   beats_pushed, stall_cycles, frames_sent;

  logic          s_ready_s, fifo_wr_s, busy_s;
  logic [DW-1:0] fifo_wdata_s;
  logic [3:0]    beats_pushed_s, stall_cycles_s, frames_sent_s;

  int tests_run;
  int tests_failed;
  int exp_beats, exp_stall, exp_frames;

  fifo_wr_serializer #(.DW(DW), .RATIO(RATIO), .CW(16)) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .flush        (flush),
    .fifo_wr      (fifo_wr),
    .fifo_wdata   (fifo_wdata),
    .fifo_wfull   (fifo_wfull),
    .busy         (busy),
    .beats_pushed (beats_pushed),
    .stall_cycles (stall_cycles),
    .frames_sent  (frames_sent)
  );

  fifo_wr_serializer #(.DW(DW), .RATIO(RATIO), .CW(4)) dut_sat (
    .wclk         (wclk),
    .wrst         (wrst),
    .s_valid      (s_valid),
    .s_ready      (s_ready_s),
    .s_data       (s_data),
    .s_last       (s_last),
    .flush        (flush),
    .fifo_wr      (fifo_wr_s),
    .fifo_wdata   (fifo_wdata_s),
    .fifo_wfull   (fifo_wfull),
    .busy         (busy_s),
    .beats_pushed (beats_pushed_s),
    .stall_cycles (stall_cycles_s),
    .frames_sent  (frames_sent_s)
  );

  // clock / reset
  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  typedef struct {
    logic          valid;
    logic [WW-1:0] data;
    logic          last;
    logic          fl;
    logic          wfull;
    logic          exp_wr;
    logic [DW-1:0] exp_wdata;
    logic          exp_ready;
    logic          exp_busy;
  } vec_t;

  vec_t vecs[16];

  // driver / checker tasks
  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WW-1:0] d, input logic l,
                       input logic f, input logic wf);
    s_valid    = v;
    s_data     = d;
    s_last     = l;
    flush      = f;
    fifo_wfull = wf;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic wr, input logic [DW-1:0] wd,
                            input logic rdy, input logic bsy);
    chk({tag, "_wr"}, int'(fifo_wr), int'(wr));
    if (wr) chk({tag, "_wdata"}, int'(fifo_wdata), int'(wd));
    chk({tag, "_ready"}, int'(s_ready), int'(rdy));
    chk({tag, "_busy"}, int'(busy), int'(bsy));
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_beats"}, int'(beats_pushed), exp_beats);
    chk({tag, "_stall"}, int'(stall_cycles), exp_stall);
    chk({tag, "_frames"}, int'(frames_sent), exp_frames);
  endtask

  initial begin
    int accepts;
    int cyc;

    tests_run    = 0;
    tests_failed = 0;
    exp_beats    = 0;
    exp_stall    = 0;
    exp_frames   = 0;

    // single word B4 (last), then words B4, 1E held valid back to back
    vecs[0]  = '{1'b1, 8'hB4, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 8'hB4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 8'h1E, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 8'h1E, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 8'h1E, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 8'h1E, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};

    wrst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();

    // reset state, still in reset
    chk("rst_wr", int'(fifo_wr), 0);
    chk("rst_wdata", int'(fifo_wdata), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(s_ready), 1);
    chk_counters("rst");
    wrst = 1'b1;
    step();

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].fl, vecs[i].wfull);
      expect_out($sformatf("vec%0d", i), vecs[i].exp_wr, vecs[i].exp_wdata,
                 vecs[i].exp_ready, vecs[i].exp_busy);
      step();
    end
    exp_beats = 12; exp_frames = 1;
    chk_counters("table");

    // wfull for 3 cycles during beat 1
    drive(1'b1, 8'hB4, 1'b1, 1'b0, 1'b0); expect_out("st_acc", 1'b0, 2'b00, 1'b1, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); expect_out("st_b0", 1'b1, 2'b00, 1'b0, 1'b1); step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      expect_out($sformatf("st_hold%0d", i), 1'b1, 2'b01, 1'b0, 1'b1);
      step();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); expect_out("st_b1", 1'b1, 2'b01, 1'b0, 1'b1); step();
    expect_out("st_b2", 1'b1, 2'b11, 1'b0, 1'b1); step();
    expect_out("st_b3", 1'b1, 2'b10, 1'b1, 1'b1); step();
    expect_out("st_idle", 1'b0, 2'b00, 1'b1, 1'b0);
    exp_beats = 16; exp_stall = 3; exp_frames = 2;
    chk_counters("stall");

    // wfull on the last beat with the next word waiting: nothing moves that cycle
    drive(1'b1, 8'hB4, 1'b1, 1'b0, 1'b0); expect_out("lw_acc", 1'b0, 2'b00, 1'b1, 1'b0); step();
    drive(1'b1, 8'h1E, 1'b0, 1'b0, 1'b0); expect_out("lw_b0", 1'b1, 2'b00, 1'b0, 1'b1); step();
    expect_out("lw_b1", 1'b1, 2'b01, 1'b0, 1'b1); step();
    expect_out("lw_b2", 1'b1, 2'b11, 1'b0, 1'b1); step();
    drive(1'b1, 8'h1E, 1'b0, 1'b0, 1'b1); expect_out("lw_full", 1'b1, 2'b10, 1'b0, 1'b1); step();
    drive(1'b1, 8'h1E, 1'b0, 1'b0, 1'b0); expect_out("lw_b3", 1'b1, 2'b10, 1'b1, 1'b1); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); expect_out("lw_n0", 1'b1, 2'b10, 1'b0, 1'b1); step();
    expect_out("lw_n1", 1'b1, 2'b11, 1'b0, 1'b1); step();
    expect_out("lw_n2", 1'b1, 2'b01, 1'b0, 1'b1); step();
    expect_out("lw_n3", 1'b1, 2'b00, 1'b1, 1'b1); step();
    expect_out("lw_idle", 1'b0, 2'b00, 1'b1, 1'b0);
    exp_beats = 24; exp_stall = 4; exp_frames = 3;
    chk_counters("lastfull");

    // flush during beat 2: beat 2 pushed, beat 3 dropped, no frame
    drive(1'b1, 8'hB4, 1'b1, 1'b0, 1'b0); expect_out("fl_acc", 1'b0, 2'b00, 1'b1, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); expect_out("fl_b0", 1'b1, 2'b00, 1'b0, 1'b1); step();
    expect_out("fl_b1", 1'b1, 2'b01, 1'b0, 1'b1); step();
    drive(1'b1, 8'h1E, 1'b1, 1'b1, 1'b0); expect_out("fl_b2", 1'b1, 2'b11, 1'b0, 1'b1); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); expect_out("fl_idle", 1'b0, 2'b00, 1'b1, 1'b0); step();
    expect_out("fl_idle2", 1'b0, 2'b00, 1'b1, 1'b0);
    exp_beats = 27;
    chk_counters("flush");
    chk("sat_pre_beats", int'(beats_pushed_s), 15);

    // asynchronous reset in the middle of beat 1
    drive(1'b1, 8'hB4, 1'b1, 1'b0, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); step();
    #2;
    wrst = 1'b0;
    #1;
    chk("ar_wr", int'(fifo_wr), 0);
    chk("ar_busy", int'(busy), 0);
    exp_beats = 0; exp_stall = 0; exp_frames = 0;
    chk_counters("areset");
    step();
    wrst = 1'b1;
    #1;
    expect_out("ar_rel", 1'b0, 2'b00, 1'b1, 1'b0);
    step();
    expect_out("ar_rel2", 1'b0, 2'b00, 1'b1, 1'b0);

    // five back-to-back words: the CW=4 copy saturates at 15
    accepts = 0;
    cyc = 0;
    drive(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    while (accepts < 5 && cyc < 60) begin
      if (s_ready) accepts++;
      step();
      cyc++;
      if (accepts == 5) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    chk("sat_accepts", accepts, 5);
    cyc = 0;
    while (busy && cyc < 20) begin
      step();
      cyc++;
    end
    chk("sat_drain", int'(busy), 0);
    chk("sat_beats16", int'(beats_pushed), 20);
    chk("sat_frames16", int'(frames_sent), 5);
    chk("sat_beats4", int'(beats_pushed_s), 15);
    chk("sat_frames4", int'(frames_sent_s), 5);
    chk("sat_stall4", int'(stall_cycles_s), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // overall time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
